sha_host_sequencer: RTL and testbench
=====================================

# sha_host_sequencer

Host-side initiator for the SHA-256 core's control block. It accepts a message as a byte stream and writes it into the message SRAM. It then pulses `go` with the message length and waits for `finish`. Finally it reads the 8-word digest back from the digest output memory (DOM) and emits it as a 32-bit valid/ready stream. It sits between the system byte source and the core's memory/handshake ports.

## Interface
- `MAX_MESSAGE_LENGTH`, 55: maximum message bytes; sets message SRAM depth.
- `OUTPUT_LENGTH`, 8: digest words read from DOM.
- `TIMEOUT_CYCLES`, 255: WAIT cycles allowed before `error` is raised. Valid range is 1..255.
- `clk` input 1: sole clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid`, `in_last` input 1: byte stream valid; `in_last` marks the final byte.
- `in_data` input 8: message byte.
- `in_ready` output 1: byte accepted when `in_valid & in_ready`.
- `xxx__msg__address` output $clog2(MAX_MESSAGE_LENGTH): message SRAM write address.
- `xxx__msg__enable`, `xxx__msg__write` output 1: SRAM enable and write.
- `xxx__msg__data` output 8: SRAM write data.
- `xxx__dut__go` output 1: one-cycle start pulse to the core.
- `xxx__dut__msg_length` output $clog2(MAX_MESSAGE_LENGTH)+1: byte count; held stable from `go` until the next load.
- `dut__xxx__finish` input 1: core completion pulse.
- `xxx__dom__address` output $clog2(OUTPUT_LENGTH): DOM read address.
- `xxx__dom__enable` output 1: DOM read enable.
- `xxx__dom__write` output 1: constant 0.
- `dom__xxx__data` input 32: DOM read data, valid 1 cycle after enable.
- `out_valid`, `out_last` output 1: digest word valid; `out_last` marks word OUTPUT_LENGTH-1.
- `out_data` output 32: digest word.
- `out_ready` input 1: downstream accept.
- `busy` output 1: state is not IDLE.
- `error` output 1: sticky error flag; cleared on the next accepted first byte.

## Operation
- Reset value of every output is 0, including `in_ready`. `in_ready` goes to 1 on the first clock after reset release.
- Valid states are IDLE, LOAD, GO, WAIT, RDREQ, RDCAP, OUT, DROP.
- IDLE and LOAD:
  - `in_ready`=1.
  - Each handshake writes `in_data` to SRAM address `cnt`, then increments `cnt`. The first byte uses `cnt`=0 and moves the FSM IDLE→LOAD.
  - A handshake with `in_last` goes to GO. `msg_length` is loaded with `cnt`+1.
- Overflow:
  - Condition: a handshake at `cnt`==MAX_MESSAGE_LENGTH-1 without `in_last`.
  - Response: set `error`, go to DROP.
  - DROP keeps `in_ready`=1, discards bytes, writes nothing, and returns to IDLE after `in_last`. No `go` is issued.
- GO: `xxx__dut__go`=1 for exactly one cycle, then WAIT. The timer is cleared to 0.
- WAIT:
  - Timer increments each cycle.
  - `finish`=1 → RDREQ with word index k=0.
  - Timer reaching TIMEOUT_CYCLES with no `finish` → set `error`, go to IDLE.
  - If `finish` arrives in the same cycle as timer expiry, `finish` wins.
- `finish` outside WAIT is ignored.
- RDREQ: `dom__enable`=1, `dom__address`=k, then RDCAP.
- RDCAP: capture `dom__xxx__data` into the output register, then OUT.
- OUT:
  - `out_valid`=1 with `out_data` held stable.
  - On `out_ready`: if k==OUTPUT_LENGTH-1 go to IDLE, else k++ and go to RDREQ.
- Counters: `cnt` saturates at MAX_MESSAGE_LENGTH-1, and k does not wrap. The timer is 8-bit.

## Timing
- SRAM port outputs (address, enable, write, data) are registered and appear the cycle after the input handshake. `enable`=`write`=1 for exactly one cycle per byte.
- `go` rises 2 cycles after the `in_last` handshake. This guarantees the last SRAM write has completed 1 cycle earlier.
- `msg_length` is valid on the `go` cycle and unchanged until the next first-byte handshake.
- Digest read is 3 cycles per word minimum with `out_ready` held at 1:
  - `out_valid` first rises 3 cycles after `finish` is sampled.
  - The full digest drains in 24 cycles.
- `out_ready`=0 stalls in OUT indefinitely with no data change.
- Reset asserted mid-operation:
  - All outputs go to 0 immediately.
  - The FSM returns to IDLE; `error` clears.
  - Any in-flight SRAM or DOM access is abandoned.

## Structure
- Shared header `sha_defs.vh` holds:
  - state encodings;
  - default MAX_MESSAGE_LENGTH, OUTPUT_LENGTH and NUMBER_OF_Hs;
  - address-width localparams (shared with the core controller).
- No sub-module is needed; this is a single FSM with three counters.

## Test plan
- "abc" (61,62,63, `in_last` on 63), with `finish` driven 88 cycles after `go`:
  - SRAM writes at addresses 0/1/2 with data 61/62/63.
  - One `go` pulse with `msg_length`=3.
  - DOM reads at addresses 0..7.
  - `out_data` is ba7816bf, 8f01cfea, …, f20015ad, with `out_last` on word 8.
- Digest backpressure, `out_ready` toggling 0/1 every 2 cycles: 8 words in order, no duplicates, `out_data` stable while `out_valid`=1 and `out_ready`=0.
- 56 bytes with `in_last` on byte 56:
  - `error`=1 after byte 55.
  - No write to address 55 or beyond, no `go`, back to IDLE after byte 56.
- `finish` never arrives: `error`=1 exactly 255 cycles after `go`, no DOM reads, IDLE.
- `finish` pulsed in IDLE: ignored. Then `reset_n` low during WAIT: all outputs 0, and a subsequent 1-byte message completes normally.
- 1-byte message 0x00: `msg_length`=1, `go` occurs 2 cycles after the handshake.

Source files
------------

// File: rtl/sha_host_sequencer_pkg.sv
// Shared definitions for the SHA-256 host sequencer: FSM encoding and default sizes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sha_host_sequencer_pkg;

    // Defaults shared with the core controller.
    localparam int DEF_MAX_MESSAGE_LENGTH = 55;
    localparam int DEF_OUTPUT_LENGTH      = 8;
    localparam int NUMBER_OF_HS           = 8;

    // WAIT-state timer width; TIMEOUT_CYCLES must fit in it.
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GO    = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RDREQ = 3'd4,
        ST_RDCAP = 3'd5,
        ST_OUT   = 3'd6,
        ST_DROP  = 3'd7
    } state_t;

endpackage

// File: rtl/sha_host_sequencer.sv
// Loads a byte-stream message into the SHA core SRAM, starts the core, streams the digest out.
// Latency: SRAM write 1 cycle after byte, go 2 cycles after last byte, 3 cycles per digest word.
// Backpressure: in_ready low outside IDLE/LOAD/DROP; OUT holds word and data until out_ready.
//
// Ports:
//   clk, reset_n                       - clock, async active-low reset
//   in_valid/in_ready/in_data/in_last  - message byte stream in
//   xxx__msg__*                        - registered message SRAM write port
//   xxx__dut__go, xxx__dut__msg_length - core start pulse and byte count
//   dut__xxx__finish                   - core completion pulse
//   xxx__dom__*, dom__xxx__data        - digest output memory read port (1-cycle read latency)
//   out_valid/out_ready/out_data/out_last - 32-bit digest word stream out
//   busy, error                        - status; error is sticky until next message starts
module sha_host_sequencer
    import sha_host_sequencer_pkg::*;
#(
    parameter int MAX_MESSAGE_LENGTH = DEF_MAX_MESSAGE_LENGTH,
    parameter int OUTPUT_LENGTH      = DEF_OUTPUT_LENGTH,
    parameter int TIMEOUT_CYCLES     = 255
) (
    input  logic                                  clk,
    input  logic                                  reset_n,

    input  logic                                  in_valid,
    input  logic                                  in_last,
    input  logic [7:0]                            in_data,
    output logic                                  in_ready,

    output logic [$clog2(MAX_MESSAGE_LENGTH)-1:0] xxx__msg__address,
    output logic                                  xxx__msg__enable,
    output logic                                  xxx__msg__write,
    output logic [7:0]                            xxx__msg__data,

    output logic                                  xxx__dut__go,
    output logic [$clog2(MAX_MESSAGE_LENGTH):0]   xxx__dut__msg_length,
    input  logic                                  dut__xxx__finish,

    output logic [$clog2(OUTPUT_LENGTH)-1:0]      xxx__dom__address,
    output logic                                  xxx__dom__enable,
    output logic                                  xxx__dom__write,
    input  logic [31:0]                           dom__xxx__data,

    output logic                                  out_valid,
    output logic                                  out_last,
    output logic [31:0]                           out_data,
    input  logic                                  out_ready,

    output logic                                  busy,
    output logic                                  error
);

    localparam int MSG_AW = $clog2(MAX_MESSAGE_LENGTH);
    localparam int LEN_W  = MSG_AW + 1;
    localparam int DOM_AW = $clog2(OUTPUT_LENGTH);

    localparam logic [MSG_AW-1:0]  CNT_MAX  = MSG_AW'(MAX_MESSAGE_LENGTH - 1);
    localparam logic [DOM_AW-1:0]  K_MAX    = DOM_AW'(OUTPUT_LENGTH - 1);
    localparam logic [TIMER_W-1:0] TMO_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

    state_t              state_q,    state_d;
    logic [MSG_AW-1:0]   cnt_q,      cnt_d;
    logic [DOM_AW-1:0]   k_q,        k_d;
    logic [TIMER_W-1:0]  timer_q,    timer_d;
    logic                in_ready_q, in_ready_d;
    logic                msg_en_q,   msg_en_d;
    logic [MSG_AW-1:0]   msg_addr_q, msg_addr_d;
    logic [7:0]          msg_data_q, msg_data_d;
    logic                go_q,       go_d;
    logic [LEN_W-1:0]    msg_len_q,  msg_len_d;
    logic [31:0]         out_data_q, out_data_d;
    logic                error_q,    error_d;

    logic                in_hs;
    logic [MSG_AW-1:0]   cur_cnt;

    assign in_hs = in_valid & in_ready_q;

    // The first byte of a message always lands at address 0, whatever cnt was left at.
    assign cur_cnt = (state_q == ST_IDLE) ? '0 : cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        k_d        = k_q;
        timer_d    = timer_q;
        msg_en_d   = 1'b0;
        msg_addr_d = msg_addr_q;
        msg_data_d = msg_data_q;
        go_d       = 1'b0;
        msg_len_d  = msg_len_q;
        out_data_d = out_data_q;
        error_d    = error_q;

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (in_hs) begin
                    msg_en_d   = 1'b1;
                    msg_addr_d = cur_cnt;
                    msg_data_d = in_data;
                    cnt_d      = (cur_cnt == CNT_MAX) ? cur_cnt : cur_cnt + 1'b1;
                    if (state_q == ST_IDLE) begin
                        error_d = 1'b0;
                    end
                    if (in_last) begin
                        msg_len_d = LEN_W'(cur_cnt) + LEN_W'(1);
                        state_d   = ST_GO;
                    end else if (cur_cnt == CNT_MAX) begin
                        // Message longer than the SRAM: swallow the rest, never start the core.
                        error_d = 1'b1;
                        state_d = ST_DROP;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_GO: begin
                go_d    = 1'b1;
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // finish takes priority over a timeout landing on the same cycle.
                if (dut__xxx__finish) begin
                    k_d     = '0;
                    state_d = ST_RDREQ;
                end else if (timer_q == TMO_LAST) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_RDREQ: begin
                state_d = ST_RDCAP;
            end
            ST_RDCAP: begin
                out_data_d = dom__xxx__data;
                state_d    = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    if (k_q == K_MAX) begin
                        state_d = ST_IDLE;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = ST_RDREQ;
                    end
                end
            end
            ST_DROP: begin
                if (in_hs && in_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered from next state so in_ready drops on the same edge that accepts in_last.
        in_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_DROP);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            k_q        <= '0;
            timer_q    <= '0;
            in_ready_q <= 1'b0;
            msg_en_q   <= 1'b0;
            msg_addr_q <= '0;
            msg_data_q <= '0;
            go_q       <= 1'b0;
            msg_len_q  <= '0;
            out_data_q <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            k_q        <= k_d;
            timer_q    <= timer_d;
            in_ready_q <= in_ready_d;
            msg_en_q   <= msg_en_d;
            msg_addr_q <= msg_addr_d;
            msg_data_q <= msg_data_d;
            go_q       <= go_d;
            msg_len_q  <= msg_len_d;
            out_data_q <= out_data_d;
            error_q    <= error_d;
        end
    end

    assign in_ready             = in_ready_q;
    assign xxx__msg__address    = msg_addr_q;
    assign xxx__msg__enable     = msg_en_q;
    assign xxx__msg__write      = msg_en_q;
    assign xxx__msg__data       = msg_data_q;
    assign xxx__dut__go         = go_q;
    assign xxx__dut__msg_length = msg_len_q;

    assign xxx__dom__enable     = (state_q == ST_RDREQ);
    assign xxx__dom__address    = (state_q == ST_RDREQ) ? k_q : '0;
    assign xxx__dom__write      = 1'b0;

    assign out_valid            = (state_q == ST_OUT);
    assign out_last             = (state_q == ST_OUT) && (k_q == K_MAX);
    assign out_data             = out_data_q;

    assign busy                 = (state_q != ST_IDLE);
    assign error                = error_q;

endmodule

// File: tb/tb_sha_host_sequencer.sv
module tb_sha_host_sequencer;

    localparam int MAXL = 55;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [6:0] len;
        int         cyc;
    } go_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } out_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [5:0]  msg_address;
    logic        msg_enable;
    logic        msg_write;
    logic [7:0]  msg_data;
    logic        go;
    logic [6:0]  msg_length;
    logic        finish = 1'b0;
    logic [2:0]  dom_address;
    logic        dom_enable;
    logic        dom_write;
    logic [31:0] dom_data = 32'h0;
    logic        out_valid;
    logic        out_last;
    logic [31:0] out_data;
    logic        out_ready = 1'b1;
    logic        busy;
    logic        error;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [31:0] digest [8] = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

    wr_t         exp_wr [$];
    go_t         exp_go [$];
    logic [2:0]  exp_rd [$];
    out_t        exp_out [$];
    int          exp_first_out = 0;
    bit          out_seen = 1'b0;
    int          last_acc_cyc = 0;
    bit          bp_en = 1'b0;
    int          bp_cnt = 0;

    sha_host_sequencer dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .in_valid             (in_valid),
        .in_last              (in_last),
        .in_data              (in_data),
        .in_ready             (in_ready),
        .xxx__msg__address    (msg_address),
        .xxx__msg__enable     (msg_enable),
        .xxx__msg__write      (msg_write),
        .xxx__msg__data       (msg_data),
        .xxx__dut__go         (go),
        .xxx__dut__msg_length (msg_length),
        .dut__xxx__finish     (finish),
        .xxx__dom__address    (dom_address),
        .xxx__dom__enable     (dom_enable),
        .xxx__dom__write      (dom_write),
        .dom__xxx__data       (dom_data),
        .out_valid            (out_valid),
        .out_last             (out_last),
        .out_data             (out_data),
        .out_ready            (out_ready),
        .busy                 (busy),
        .error                (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Digest output memory: one-cycle read latency.
    always @(posedge clk) begin
        if (dom_enable) dom_data <= digest[dom_address];
    end

    // Downstream sink: ready held high, or toggling every 2 cycles when backpressure is on.
    always @(posedge clk) begin
        #1;
        bp_cnt = bp_cnt + 1;
        out_ready = bp_en ? bp_cnt[1] : 1'b1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected or missing event (cycle %0d)", name, cyc);
    endtask

    // ---------------- scoreboard monitors ----------------
    always @(negedge clk) begin
        if (reset_n && msg_enable) begin
            if (exp_wr.size() == 0) begin
                report_fail("sram_extra_write");
            end else begin
                check("sram_addr",  msg_address, exp_wr[0].addr);
                check("sram_data",  msg_data,    exp_wr[0].data);
                check("sram_write", msg_write,   1);
                void'(exp_wr.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && go) begin
            if (exp_go.size() == 0) begin
                report_fail("go_extra");
            end else begin
                check("go_msg_length", msg_length, exp_go[0].len);
                check("go_cycle",      cyc,        exp_go[0].cyc);
                void'(exp_go.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && dom_enable) begin
            if (exp_rd.size() == 0) begin
                report_fail("dom_extra_read");
            end else begin
                check("dom_addr",  dom_address, exp_rd[0]);
                check("dom_write", dom_write,   0);
                void'(exp_rd.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (exp_out.size() == 0) begin
                report_fail("out_extra_word");
            end else begin
                if (!out_seen) begin
                    check("first_out_cycle", cyc, exp_first_out);
                    out_seen = 1'b1;
                end
                check("out_data", out_data, exp_out[0].data);
                check("out_last", out_last, exp_out[0].last);
                if (out_ready) begin
                    void'(exp_out.pop_front());
                    last_acc_cyc = cyc;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] d, input logic l, output int hs);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        do begin
            @(negedge clk);
            guard++;
        end while (!in_ready && guard < 100);
        hs = cyc;
        if (!in_ready) report_fail("in_ready_timeout");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Sends bytes base, base+1, ... with in_last on the n-th; queues the expected writes and go.
    task automatic send_msg(input int n, input logic [7:0] base, output int last_hs);
        int hs;
        hs = 0;
        for (int i = 0; i < n; i++) begin
            if (i < MAXL) exp_wr.push_back('{addr: 6'(i), data: 8'(base + 8'(i))});
            send_byte(8'(base + 8'(i)), i == n - 1, hs);
            if (i == n - 1 && n <= MAXL) exp_go.push_back('{len: 7'(n), cyc: hs + 2});
            if (n > MAXL && i == MAXL - 1) begin
                @(negedge clk);
                check("overflow_error", error, 1);
                @(posedge clk);
                #1;
            end
        end
        last_hs = hs;
    endtask

    task automatic wait_go(output int g);
        int n;
        n = 0;
        g = -1;
        while (n < 200 && g < 0) begin
            @(negedge clk);
            n++;
            if (go) g = cyc;
        end
        if (g < 0) report_fail("go_timeout");
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        if (busy) report_fail(name);
    endtask

    task automatic arm_digest(input int f);
        for (int k = 0; k < 8; k++) begin
            exp_rd.push_back(3'(k));
            exp_out.push_back('{data: digest[k], last: (k == 7)});
        end
        exp_first_out = f + 3;
        out_seen = 1'b0;
    endtask

    // Drives finish high during cycle x (sampled by the DUT at the edge ending that cycle).
    task automatic pulse_finish_at(input int x);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < x);
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
    endtask

    task automatic check_queues_empty(input string tag);
        check({tag, "_wr_left"},  exp_wr.size(),  0);
        check({tag, "_go_left"},  exp_go.size(),  0);
        check({tag, "_rd_left"},  exp_rd.size(),  0);
        check({tag, "_out_left"}, exp_out.size(), 0);
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        int hs;
        int g;
        int n;

        #1 reset_n = 1'b0;
        #3;
        check("rst_in_ready",  in_ready,   0);
        check("rst_busy",      busy,       0);
        check("rst_error",     error,      0);
        check("rst_msg_en",    msg_enable, 0);
        check("rst_go",        go,         0);
        check("rst_out_valid", out_valid,  0);
        check("rst_dom_en",    dom_enable, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready_still_0", in_ready, 0);
        @(negedge clk);
        check("in_ready_after_release", in_ready, 1);
        @(posedge clk);
        #1;

        // "abc", finish 88 cycles after go, ready held high.
        send_msg(3, 8'h61, hs);
        wait_go(g);
        arm_digest(g + 88);
        pulse_finish_at(g + 88);
        wait_idle("abc_drain_timeout", 100);
        check("abc_drain_cycle", last_acc_cyc, g + 88 + 24);
        check("abc_len_held", msg_length, 3);
        check_queues_empty("abc");

        // Same message, digest drained against a toggling ready.
        @(posedge clk);
        #1;
        send_msg(3, 8'h61, hs);
        wait_go(g);
        arm_digest(g + 5);
        bp_en = 1'b1;
        pulse_finish_at(g + 5);
        wait_idle("bp_drain_timeout", 200);
        bp_en = 1'b0;
        check_queues_empty("bp");

        // 56-byte message: overflow on byte 55, dropped, no go.
        @(posedge clk);
        #1;
        send_msg(56, 8'h00, hs);
        @(negedge clk);
        check("ovf_idle", busy, 0);
        check("ovf_in_ready", in_ready, 1);
        check("ovf_error_sticky", error, 1);
        repeat (5) @(negedge clk);
        check_queues_empty("ovf");

        // Timeout: first byte clears error, no finish ever.
        @(posedge clk);
        #1;
        send_msg(1, 8'haa, hs);
        @(negedge clk);
        check("error_cleared_first_byte", error, 0);
        wait_go(g);
        n = 0;
        while (!error && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycle", cyc, g + 255);
        check("timeout_error", error, 1);
        check("timeout_idle", busy, 0);
        check_queues_empty("tmo");

        // finish on the exact expiry cycle must win.
        @(posedge clk);
        #1;
        send_msg(2, 8'h01, hs);
        wait_go(g);
        arm_digest(g + 254);
        pulse_finish_at(g + 254);
        wait_idle("expiry_drain_timeout", 100);
        check("expiry_no_error", error, 0);
        check_queues_empty("expiry");

        // finish while idle is ignored.
        @(posedge clk);
        #1;
        finish = 1'b1;
        @(posedge clk);
        #1;
        finish = 1'b0;
        repeat (6) @(negedge clk);
        check("idle_finish_busy", busy, 0);
        check_queues_empty("idlefin");

        // Reset asserted while waiting for the core.
        @(posedge clk);
        #1;
        send_msg(1, 8'h11, hs);
        wait_go(g);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_in_ready",  in_ready,   0);
        check("midrst_busy",      busy,       0);
        check("midrst_go",        go,         0);
        check("midrst_msg_len",   msg_length, 0);
        check("midrst_out_valid", out_valid,  0);
        check("midrst_msg_en",    msg_enable, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_in_ready_back", in_ready, 1);
        @(posedge clk);
        #1;

        // Single byte 0x00 after reset completes normally.
        send_msg(1, 8'h00, hs);
        wait_go(g);
        check("one_byte_go_delay", g - hs, 2);
        arm_digest(g + 3);
        pulse_finish_at(g + 3);
        wait_idle("one_byte_drain_timeout", 100);
        check("one_byte_len", msg_length, 1);
        check_queues_empty("onebyte");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
